// File: rtl/stream_mux_4to1.sv
// Four-input valid/ready stream multiplexer with round-robin arbitration
// into a single registered output stage tagged with the source channel.
module stream_mux_4to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  input  logic             in3_valid,
  input  logic [WIDTH-1:0] in3_data,
  output logic             in3_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sel0,
  output logic             out_sel1
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;

  logic [NCH-1:0]   valid_vec;
  logic [NCH-1:0]   ready_vec;
  logic [WIDTH-1:0] data_arr [NCH];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  sel_q,       sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  scan_idx;

  assign valid_vec   = {in3_valid, in2_valid, in1_valid, in0_valid};
  assign data_arr[0] = in0_data;
  assign data_arr[1] = in1_data;
  assign data_arr[2] = in2_data;
  assign data_arr[3] = in3_data;
  assign {in3_ready, in2_ready, in1_ready, in0_ready} = ready_vec;

  // Round-robin search starting at ptr; rst_n gating keeps readys low in reset.
  always_comb begin
    load      = !out_valid_q || out_ready;
    grant_any = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      scan_idx = ptr_q + SELW'(i);
      if (!grant_any && valid_vec[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    grant_any = grant_any && load && rst_n;
    ready_vec = '0;
    if (grant_any) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  // Output stage: drain and refill in the same edge; empties when nothing is granted.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_any) begin
        out_valid_d = 1'b1;
        out_data_d  = data_arr[grant_idx];
        sel_d       = grant_idx;
        ptr_d       = grant_idx + SELW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel0  = sel_q[0];
  assign out_sel1  = sel_q[1];

endmodule
